// File: rtl/oled_pkg.sv
// Shared OLED screen constants, region bounds and the loading-screen state type.
package oled_pkg;

  // RGB565 colours
  localparam logic [15:0] WHITE      = 16'hFFFF;
  localparam logic [15:0] BLACK      = 16'h0000;
  localparam logic [15:0] LIGHTGREEN = 16'hAFE5;
  localparam logic [15:0] RED        = 16'hF800;
  localparam logic [15:0] BG_DEFAULT = WHITE;

  // Panel dimensions
  localparam int unsigned SCREEN_W = 96;
  localparam int unsigned SCREEN_H = 64;

  // Loading-bar segment rows and columns
  localparam logic [5:0] BAR_Y_MIN = 6'd30;
  localparam logic [5:0] BAR_Y_MAX = 6'd45;

  // Rules-text block
  localparam logic [6:0] TEXT_X_MIN = 7'd10;
  localparam logic [6:0] TEXT_X_MAX = 7'd87;
  localparam logic [5:0] TEXT_Y_MIN = 6'd51;
  localparam logic [5:0] TEXT_Y_MAX = 6'd61;

  // Left column of bar segment k
  function automatic logic [6:0] seg_x_min(input logic [1:0] k);
    case (k)
      2'd0:    seg_x_min = 7'd14;
      2'd1:    seg_x_min = 7'd32;
      2'd2:    seg_x_min = 7'd51;
      default: seg_x_min = 7'd69;
    endcase
  endfunction

  // Right column of bar segment k
  function automatic logic [6:0] seg_x_max(input logic [1:0] k);
    case (k)
      2'd0:    seg_x_max = 7'd30;
      2'd1:    seg_x_max = 7'd49;
      2'd2:    seg_x_max = 7'd67;
      default: seg_x_max = 7'd85;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2,
    ST_DONE    = 2'd3
  } ls_state_e;

endpackage

// File: rtl/bar_region_decode.sv
// Combinational decode of a pixel coordinate into loading-bar segment and
// rules-text region hits. Coordinates outside the panel never hit.
module bar_region_decode
  import oled_pkg::*;
(
  input  logic [6:0] x,
  input  logic [5:0] y,
  output logic [3:0] seg_hit,
  output logic       text_hit
);

  logic bar_row;

  // Segment and text region membership for the current coordinate
  always_comb begin
    seg_hit  = '0;
    bar_row  = (y >= BAR_Y_MIN) && (y <= BAR_Y_MAX);
    for (int unsigned k = 0; k < 4; k++) begin
      seg_hit[k] = bar_row
                && (x >= seg_x_min(k[1:0]))
                && (x <= seg_x_max(k[1:0]));
    end
    text_hit = (y >= TEXT_Y_MIN) && (y <= TEXT_Y_MAX)
            && (x >= TEXT_X_MIN) && (x <= TEXT_X_MAX);
  end

endmodule

// File: rtl/loading_screen_sequencer.sv
// Loading-screen sequencer: fills the four-segment bar over time, blinks the
// rules text until continue is pressed, pulses game_start, and masks the
// renderer's pixel stream accordingly with one cycle of latency.
module loading_screen_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned SEG_TICKS   = 250,
  parameter int unsigned BLINK_TICKS = 500,
  parameter logic [15:0] BG_COLOUR   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        abort,
  input  logic        btn_continue,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [15:0] pixel_in,
  output logic [15:0] oled_data,
  output logic [2:0]  seg_count,
  output logic        busy,
  output logic        game_start
);

  localparam int unsigned TCW = (SEG_TICKS   > 1) ? $clog2(SEG_TICKS)   : 1;
  localparam int unsigned BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(SEG_TICKS - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLINK_TICKS - 1);

  ls_state_e      state_q, state_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;
  logic [2:0]     seg_q, seg_d;
  logic           busy_q, busy_d;
  logic           gs_q, gs_d;
  logic [15:0]    oled_q, oled_d;

  logic [3:0]     seg_hit;
  logic           text_hit;
  logic [3:0]     seg_lit;
  logic           mask;

  bar_region_decode u_decode (
    .x        (x),
    .y        (y),
    .seg_hit  (seg_hit),
    .text_hit (text_hit)
  );

  // Next state and counters; abort overrides transitions, transitions override tick
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    seg_d       = seg_q;
    gs_d        = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      seg_d       = '0;
      tick_cnt_d  = '0;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_LOADING;
            seg_d      = '0;
            tick_cnt_d = '0;
          end
        end
        ST_LOADING: begin
          if (tick) begin
            if (tick_cnt_q == TC_LAST) begin
              tick_cnt_d = '0;
              seg_d      = seg_q + 3'd1;
              if (seg_q == 3'd3) begin
                state_d     = ST_READY;
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (btn_continue) begin
            state_d    = ST_DONE;
            gs_d       = 1'b1;
            blink_on_d = 1'b1;
          end else if (tick) begin
            if (blink_cnt_q == BC_LAST) begin
              blink_cnt_d = '0;
              blink_on_d  = ~blink_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          blink_on_d = 1'b1;
          if (start) begin
            state_d    = ST_LOADING;
            seg_d      = '0;
            tick_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Pixel mask: unlit segments, and rules text during the blink-off phase
  always_comb begin
    seg_lit = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      seg_lit[k] = (3'(k) < seg_q);
    end
    mask = (|(seg_hit & ~seg_lit))
        || (text_hit && (state_q == ST_READY) && !blink_on_q);
    oled_d = mask ? BG_COLOUR : pixel_in;
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= '0;
      busy_q      <= 1'b0;
      gs_q        <= 1'b0;
      oled_q      <= BG_COLOUR;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      busy_q      <= busy_d;
      gs_q        <= gs_d;
      oled_q      <= oled_d;
    end
  end

  assign oled_data  = oled_q;
  assign seg_count  = seg_q;
  assign busy       = busy_q;
  assign game_start = gs_q;

endmodule

// File: tb/tb_loading_screen_sequencer.sv
// Directed bench for loading_screen_sequencer with SEG_TICKS=4, BLINK_TICKS=3.
module tb_loading_screen_sequencer;

  logic        clk = 1'b0;
  logic        reset, tick, start, abort, btn_continue;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] pixel_in;
  logic [15:0] oled_data;
  logic [2:0]  seg_count;
  logic        busy, game_start;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  loading_screen_sequencer #(
    .SEG_TICKS   (4),
    .BLINK_TICKS (3),
    .BG_COLOUR   (16'hFFFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start        (start),
    .abort        (abort),
    .btn_continue (btn_continue),
    .x            (x),
    .y            (y),
    .pixel_in     (pixel_in),
    .oled_data    (oled_data),
    .seg_count    (seg_count),
    .busy         (busy),
    .game_start   (game_start)
  );

  typedef struct {
    logic        tick, start, abort, btn;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] pix;
    logic [15:0] e_oled;
    logic [2:0]  e_seg;
    logic        e_busy, e_gs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input logic s, input logic a, input logic b,
                     input logic [6:0] vx, input logic [5:0] vy, input logic [15:0] p,
                     input logic [15:0] eo, input logic [2:0] es,
                     input logic eb, input logic eg);
    vec_t v;
    v.tick = t; v.start = s; v.abort = a; v.btn = b;
    v.x = vx; v.y = vy; v.pix = p;
    v.e_oled = eo; v.e_seg = es; v.e_busy = eb; v.e_gs = eg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    tick = 0; start = 0; abort = 0; btn_continue = 0;
  endtask

  task automatic run_ticks(input int n);
    tick = 1;
    for (int i = 0; i < n; i++) step();
    tick = 0;
  endtask

  initial begin
    reset = 1; clear_in();
    x = 7'd20; y = 6'd35; pixel_in = 16'hAFE5;

    // x, y = 20,35 is segment 0; 75,35 is segment 3; 12,51 is rules text
    add(1,1,0,0, 20,35,16'hAFE5, 16'hFFFF,0,1,0); // start+tick: tick not counted
    add(1,0,0,0, 20,35,16'hAFE5, 16'hFFFF,0,1,0);
    add(1,0,0,0, 20,35,16'hAFE5, 16'hFFFF,0,1,0);
    add(1,0,0,0, 20,35,16'hAFE5, 16'hFFFF,0,1,0);
    add(1,0,0,0, 20,35,16'hAFE5, 16'hFFFF,1,1,0); // 4th tick
    add(1,0,0,0, 75,35,16'hAFE5, 16'hFFFF,1,1,0);
    add(1,0,0,0, 20,35,16'hAFE5, 16'hAFE5,1,1,0);
    add(1,0,0,1, 75,35,16'hAFE5, 16'hFFFF,1,1,0); // continue ignored while loading
    add(1,0,0,0, 50,35,16'hAFE5, 16'hAFE5,2,1,0); // 8th tick; gap column
    add(1,0,0,0, 32,35,16'hAFE5, 16'hAFE5,2,1,0);
    add(1,0,0,0, 51,35,16'hAFE5, 16'hFFFF,2,1,0);
    add(1,0,0,0, 20,29,16'hAFE5, 16'hAFE5,2,1,0);
    add(1,0,0,0, 20,46,16'hAFE5, 16'hAFE5,3,1,0); // 12th tick
    add(1,0,0,0, 67,45,16'hAFE5, 16'hAFE5,3,1,0);
    add(1,0,0,0, 69,30,16'hAFE5, 16'hFFFF,3,1,0);
    add(1,0,0,0, 85,35,16'hAFE5, 16'hFFFF,3,1,0);
    add(1,0,0,0, 75,35,16'hAFE5, 16'hFFFF,4,1,0); // 16th tick -> READY
    add(0,0,0,0, 75,35,16'hAFE5, 16'hAFE5,4,1,0);
    add(1,0,0,0, 12,51,16'hF800, 16'hF800,4,1,0);
    add(1,0,0,0, 12,51,16'hF800, 16'hF800,4,1,0);
    add(1,0,0,0, 12,51,16'hF800, 16'hF800,4,1,0); // 3rd tick: blink off
    add(0,0,0,0, 12,51,16'hF800, 16'hFFFF,4,1,0);
    add(1,0,0,0, 87,61,16'hF800, 16'hFFFF,4,1,0);
    add(1,0,0,0, 11,35,16'h0000, 16'h0000,4,1,0); // outline never masked
    add(1,0,0,0, 12,51,16'hF800, 16'hFFFF,4,1,0); // toggles back on
    add(1,0,0,0, 88,61,16'hF800, 16'hF800,4,1,0);
    add(1,0,0,0, 12,51,16'hF800, 16'hF800,4,1,0);
    add(1,0,0,1, 12,51,16'hF800, 16'hF800,4,1,1); // continue + toggling tick
    add(0,0,0,0, 12,51,16'hF800, 16'hF800,4,1,0);
    add(1,0,0,0, 12,51,16'hF800, 16'hF800,4,1,0);
    add(0,0,0,1, 12,51,16'hF800, 16'hF800,4,1,0); // continue in DONE: no pulse
    add(0,0,1,0, 20,35,16'hAFE5, 16'hAFE5,0,0,0); // abort from DONE
    add(1,0,0,1, 20,35,16'hAFE5, 16'hFFFF,0,0,0);
    add(0,0,0,0,100,35,16'hAFE5, 16'hAFE5,0,0,0); // off-panel passes through

    step(); step();
    chk("reset_oled", oled_data, 16'hFFFF);
    chk("reset_seg",  {13'd0, seg_count}, 16'd0);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_gs",   {15'd0, game_start}, 16'd0);
    reset = 0;

    foreach (vecs[i]) begin
      tick = vecs[i].tick; start = vecs[i].start;
      abort = vecs[i].abort; btn_continue = vecs[i].btn;
      x = vecs[i].x; y = vecs[i].y; pixel_in = vecs[i].pix;
      step();
      chk($sformatf("v%0d_oled", i), oled_data, vecs[i].e_oled);
      chk($sformatf("v%0d_seg", i),  {13'd0, seg_count}, {13'd0, vecs[i].e_seg});
      chk($sformatf("v%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_gs", i),   {15'd0, game_start}, {15'd0, vecs[i].e_gs});
    end
    clear_in();
    x = 7'd20; y = 6'd35; pixel_in = 16'hAFE5;

    // Abort at seg_count=2, then restart from zero
    start = 1; step(); start = 0;
    run_ticks(8);
    chk("abort_pre_seg", {13'd0, seg_count}, 16'd2);
    abort = 1; tick = 1; step(); clear_in();
    chk("abort_seg",  {13'd0, seg_count}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    start = 1; step(); start = 0;
    chk("restart_busy", {15'd0, busy}, 16'd1);
    chk("restart_seg",  {13'd0, seg_count}, 16'd0);
    run_ticks(4);
    chk("restart_seg1", {13'd0, seg_count}, 16'd1);
    abort = 1; step(); clear_in();

    // Reset while READY, with start in the same cycle
    start = 1; step(); start = 0;
    run_ticks(16);
    chk("rr_pre_seg", {13'd0, seg_count}, 16'd4);
    reset = 1; start = 1; tick = 1; step();
    chk("rr_oled", oled_data, 16'hFFFF);
    chk("rr_seg",  {13'd0, seg_count}, 16'd0);
    chk("rr_busy", {15'd0, busy}, 16'd0);
    chk("rr_gs",   {15'd0, game_start}, 16'd0);
    reset = 0; clear_in(); step();
    chk("rr_post_busy", {15'd0, busy}, 16'd0);
    chk("rr_post_oled", oled_data, 16'hFFFF);

    // DONE restarts loading on start; game_start lasts one cycle
    start = 1; step(); start = 0;
    run_ticks(16);
    btn_continue = 1; step(); btn_continue = 0;
    chk("done_gs", {15'd0, game_start}, 16'd1);
    start = 1; step(); start = 0;
    chk("done_gs_drop", {15'd0, game_start}, 16'd0);
    chk("done_restart_busy", {15'd0, busy}, 16'd1);
    chk("done_restart_seg", {13'd0, seg_count}, 16'd0);
    run_ticks(4);
    chk("done_restart_seg1", {13'd0, seg_count}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
